// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
// Holds the width limit and a plain-arithmetic reference for {carry, sum}.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Returns {carry, sum} in bits [width:0]; upper bits are zero.
  function automatic logic [MAX_WIDTH:0] fa_ref(input logic [MAX_WIDTH-1:0] a,
                                                input logic [MAX_WIDTH-1:0] b,
                                                input logic                 cin,
                                                input int                   width);
    logic [MAX_WIDTH:0] mask;
    logic [MAX_WIDTH:0] full;
    mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{MAX_WIDTH{1'b0}}, cin};
    return full;
  endfunction

endpackage

// File: rtl/full_adder_unit_fa_cell.sv
// Combinational 1-bit full-adder cell, the building block of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic ca
);

  assign sum = a ^ b ^ cin;
  assign ca  = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry full adder with a valid flag.
// Optional FULL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             ca,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("full_adder_unit: WIDTH out of range");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_p1;
  logic             ca_p1;
  logic             vld_p1;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (s[i]),
      .ca  (c[i+1])
    );
  end

  // Stage p1: output register; data holds when no valid input arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      ca_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1 <= s;
        ca_p1  <= c[WIDTH];
      end
    end
  end

  assign sum       = sum_p1;
  assign ca        = ca_p1;
  assign out_valid = vld_p1;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_p1;

  // For WIDTH=1, c[WIDTH-1] is c[0], i.e. cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      ovf_p1 <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

  assign ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH = 1, 8 and 16.
module tb_full_adder_unit;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        v1, a1, b1, cin1;
  logic        s1, ca1, ov1;
  logic        v8, cin8;
  logic [7:0]  a8, b8, s8;
  logic        ca8, ov8;
  logic        v16, cin16;
  logic [15:0] a16, b16, s16;
  logic        ca16, ov16;
`ifdef FULL_ADDER_OVF_EN
  logic o1, o8, o16;
`endif

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .sum(s1), .ca(ca1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(o1)
`endif
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
    .sum(s8), .ca(ca8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(o8)
`endif
  );

  full_adder_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(cin16),
    .sum(s16), .ca(ca16), .out_valid(ov16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(o16)
`endif
  );

  task automatic test_reset();
    v1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    v8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    v16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s1, ca1, ov1} !== 3'b000) begin
      bad++; $display("FAIL reset_w1 got=%b expected=000", {s1, ca1, ov1});
    end
    total++;
    if ({s8, ca8, ov8} !== 10'h000) begin
      bad++; $display("FAIL reset_w8 got=%h expected=000", {s8, ca8, ov8});
    end
    total++;
    if ({s16, ca16, ov16} !== 18'h00000) begin
      bad++; $display("FAIL reset_w16 got=%h expected=00000", {s16, ca16, ov16});
    end
`ifdef FULL_ADDER_OVF_EN
    total++;
    if ({o1, o8, o16} !== 3'b000) begin
      bad++; $display("FAIL reset_ovf got=%b expected=000", {o1, o8, o16});
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] t;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1; a1 = i[2]; b1 = i[1]; cin1 = i[0];
      t = 2'(a1) + 2'(b1) + 2'(cin1);
      @(posedge clk); #1;
      total++;
      if ({s1, ca1, ov1} !== {t[0], t[1], 1'b1}) begin
        bad++;
        $display("FAIL exh_w1 abc=%0d got sum,ca,vld=%b expected=%b", i, {s1, ca1, ov1}, {t[0], t[1], 1'b1});
      end
    end
    @(negedge clk) v1 = 0;
  endtask

  task automatic test_directed_w8();
    logic [7:0] ta [6] = '{8'hFF, 8'hFF, 8'h12, 8'h7F, 8'h80, 8'h10};
    logic [7:0] tb [6] = '{8'h01, 8'hFF, 8'h34, 8'h01, 8'h80, 8'h20};
    logic       tc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] es [6] = '{8'h00, 8'hFF, 8'h47, 8'h80, 8'h00, 8'h30};
    logic       ec [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v8 = 1; a8 = ta[i]; b8 = tb[i]; cin8 = tc[i];
      @(posedge clk); #1;
      total++;
      if ({s8, ca8, ov8} !== {es[i], ec[i], 1'b1}) begin
        bad++;
        $display("FAIL dir_w8[%0d] got sum=%h ca=%b vld=%b expected sum=%h ca=%b vld=1",
                 i, s8, ca8, ov8, es[i], ec[i]);
      end
`ifdef FULL_ADDER_OVF_EN
      total++;
      if (o8 !== eo[i]) begin
        bad++; $display("FAIL ovf_w8[%0d] got=%b expected=%b", i, o8, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unreachable");
`endif
    end
    @(negedge clk) v8 = 0;
  endtask

  task automatic test_hold_w1();
    @(negedge clk);
    v1 = 1; a1 = 1; b1 = 0; cin1 = 0;
    @(posedge clk); #1;
    total++;
    if ({s1, ca1, ov1} !== 3'b101) begin
      bad++; $display("FAIL hold_load got=%b expected=101", {s1, ca1, ov1});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v1 = 0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      @(posedge clk); #1;
      total++;
      if ({s1, ca1, ov1} !== 3'b100) begin
        bad++; $display("FAIL hold[%0d] got=%b expected=100", i, {s1, ca1, ov1});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({s1, ca1, ov1} !== 3'b000) begin
      bad++; $display("FAIL reset_mid got=%b expected=000", {s1, ca1, ov1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1; a1 = 1; b1 = 1; cin1 = 0;
    @(posedge clk); #1;
    total++;
    if ({s1, ca1, ov1} !== 3'b011) begin
      bad++; $display("FAIL post_reset got=%b expected=011", {s1, ca1, ov1});
    end
    @(negedge clk) v1 = 0;
  endtask

  task automatic test_random_w16();
    logic [16:0] exp_res = '0;
    logic [64:0] r;
    logic        exp_v;
    logic        exp_o = 1'b0;
    longint      sv;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      v16 = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      exp_v = v16;
      if (v16) begin
        r = fa_ref({48'h0, a16}, {48'h0, b16}, cin16, 16);
        exp_res = r[16:0];
        sv = longint'($signed(a16)) + longint'($signed(b16)) + longint'(cin16);
        exp_o = (sv > 32767) || (sv < -32768);
      end
      @(posedge clk); #1;
      total++;
      if ({ca16, s16, ov16} !== {exp_res, exp_v}) begin
        bad++;
        $display("FAIL rand_w16[%0d] got ca,sum=%h vld=%b expected ca,sum=%h vld=%b",
                 n, {ca16, s16}, ov16, exp_res, exp_v);
      end
`ifdef FULL_ADDER_OVF_EN
      total++;
      if (o16 !== exp_o) begin
        bad++; $display("FAIL rand_ovf[%0d] got=%b expected=%b", n, o16, exp_o);
      end
`else
      if (exp_o === 1'bx) $display("unreachable");
`endif
    end
    @(negedge clk) v16 = 0;
  endtask

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_directed_w8();
    test_hold_w1();
    test_reset_mid();
    test_random_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
